// File: rtl/bus_arbiter_mux_pkg.sv
// Shared bus definitions: active-low levels, direction encodings, default widths
// and the arbiter state encoding.
package bus_arbiter_mux_pkg;

   localparam logic ENABLE_  = 1'b0;
   localparam logic DISABLE_ = 1'b1;
   localparam logic READ     = 1'b1;
   localparam logic WRITE    = 1'b0;

   localparam int DEF_ADDR_W = 30;
   localparam int DEF_DATA_W = 32;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } arb_state_t;

endpackage

// File: rtl/bus_arbiter_mux_rr_pick.sv
// Combinational round-robin picker: returns the first set request found
// searching base+1, base+2, ... with wrap, so the base itself is searched last.
module bus_arbiter_mux_rr_pick #(
   parameter int N  = 4,
   parameter int IW = 2
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] base,
   output logic          found,
   output logic [IW-1:0] index
);

   int cand;

   // rotating search for the first requester after base
   always_comb begin
      found = 1'b0;
      index = '0;
      cand  = 0;
      for (int i = 1; i <= N; i++) begin
         cand = int'(base) + i;
         if (cand >= N) begin
            cand = cand - N;
         end else begin
            cand = cand;
         end
         if (!found && req[cand]) begin
            found = 1'b1;
            index = IW'(cand);
         end else begin
            found = found;
         end
      end
   end

endmodule

// File: rtl/bus_arbiter_mux.sv
// Round-robin bus arbiter with registered active-low grants and a master-to-slave
// multiplexer driven only by the registered owner.
module bus_arbiter_mux
   import bus_arbiter_mux_pkg::*;
#(
   parameter int N_MASTERS = 4,
   parameter int ADDR_W    = DEF_ADDR_W,
   parameter int DATA_W    = DEF_DATA_W,
   parameter int MAX_HOLD  = 16
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [N_MASTERS-1:0]          m_req_,
   input  logic [N_MASTERS*ADDR_W-1:0]   m_addr,
   input  logic [N_MASTERS-1:0]          m_as_,
   input  logic [N_MASTERS-1:0]          m_rw,
   input  logic [N_MASTERS*DATA_W-1:0]   m_wr_data,
   output logic [N_MASTERS-1:0]          m_grnt_,
   output logic [ADDR_W-1:0]             s_addr,
   output logic                          s_as_,
   output logic                          s_rw,
   output logic [DATA_W-1:0]             s_wr_data,
   output logic [$clog2(N_MASTERS)-1:0]  owner,
   output logic                          busy
);

   localparam int OW   = $clog2(N_MASTERS);
   localparam int HC_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
   localparam logic [HC_W-1:0] HOLD_TOP = HC_W'((MAX_HOLD > 1) ? MAX_HOLD - 1 : 0);

   arb_state_t              state_r;
   logic [N_MASTERS-1:0]    grnt_r;
   logic                    busy_r;
   logic [OW-1:0]           owner_r;
   logic [OW-1:0]           last_r;
   logic [HC_W-1:0]         hold_r;

   logic [N_MASTERS-1:0]    req_s;
   logic [N_MASTERS-1:0]    others_s;
   logic [OW-1:0]           base_s;
   logic                    force_s;
   logic                    release_s;
   logic                    pick_found_s;
   logic [OW-1:0]           pick_idx_s;

   function automatic logic [N_MASTERS-1:0] one_cold(input logic [OW-1:0] idx);
      logic [N_MASTERS-1:0] v;
      v = '1;
      v[idx] = ENABLE_;
      return v;
   endfunction

   // request decode, hold-limit and release conditions
   always_comb begin
      req_s            = ~m_req_;
      others_s         = req_s;
      others_s[owner_r] = 1'b0;
      if (state_r == ST_GRANT) begin
         base_s = owner_r;
      end else begin
         base_s = last_r;
      end
      // a strobed access is never cut by the hold limit
      force_s   = (MAX_HOLD != 0) && (hold_r == HOLD_TOP) && (|others_s)
                  && (m_as_[owner_r] == DISABLE_);
      release_s = !req_s[owner_r] || force_s;
   end

   bus_arbiter_mux_rr_pick #(
      .N  (N_MASTERS),
      .IW (OW)
   ) u_rr_pick (
      .req   (req_s),
      .base  (base_s),
      .found (pick_found_s),
      .index (pick_idx_s)
   );

   // arbitration FSM with registered grant, owner, busy and hold counter
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= ST_IDLE;
         grnt_r  <= '1;
         busy_r  <= 1'b0;
         owner_r <= '0;
         last_r  <= OW'(N_MASTERS - 1);
         hold_r  <= '0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (pick_found_s) begin
                  state_r <= ST_GRANT;
                  grnt_r  <= one_cold(pick_idx_s);
                  busy_r  <= 1'b1;
                  owner_r <= pick_idx_s;
                  hold_r  <= '0;
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_GRANT: begin
               if (release_s) begin
                  last_r <= owner_r;
                  hold_r <= '0;
                  if (pick_found_s) begin
                     grnt_r  <= one_cold(pick_idx_s);
                     owner_r <= pick_idx_s;
                  end else begin
                     state_r <= ST_IDLE;
                     grnt_r  <= '1;
                     busy_r  <= 1'b0;
                  end
               end else if (hold_r != HOLD_TOP) begin
                  hold_r <= hold_r + HC_W'(1);
               end else begin
                  hold_r <= hold_r;
               end
            end
            default: begin
               state_r <= ST_IDLE;
               grnt_r  <= '1;
               busy_r  <= 1'b0;
               hold_r  <= '0;
            end
         endcase
      end
   end

   // slave-side mux; depends only on registered owner/busy
   always_comb begin
      if (busy_r) begin
         s_addr    = m_addr[owner_r*ADDR_W +: ADDR_W];
         s_as_     = m_as_[owner_r];
         s_rw      = m_rw[owner_r];
         s_wr_data = m_wr_data[owner_r*DATA_W +: DATA_W];
      end else begin
         s_addr    = '0;
         s_as_     = DISABLE_;
         s_rw      = READ;
         s_wr_data = '0;
      end
   end

   assign m_grnt_ = grnt_r;
   assign owner   = owner_r;
   assign busy    = busy_r;

endmodule
